// File: rtl/riscv_reset_pkg.sv
// riscv_reset_pkg: shared state/cause encodings for the reset sequencer
package riscv_reset_pkg;
  typedef enum logic [1:0] {S_HOLD, S_MEM, S_RUN} rst_state_t;
  typedef enum logic [1:0] {CAUSE_POR = 2'd0, CAUSE_BTN = 2'd1, CAUSE_WDT = 2'd2} reset_cause_t;
  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/riscv_btn_debounce.sv
// riscv_btn_debounce: 2-flop synchroniser plus debounce for the board reset button
//  clk_i/reset_i : clock, synchronous active-high reset
//  btn_i         : raw async button, high = reset request
//  stable_o      : debounced button level
//  btn_req_o     : one-cycle pulse, high on the cycle the debounced level rises
module riscv_btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  output logic stable_o,
  output logic btn_req_o
);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  logic          meta;
  logic          sync;
  logic [DW-1:0] dcnt;
  logic          flip;
  // the debounced level flips once sync has disagreed for DEBOUNCE_CYCLES cycles in a row
  assign flip      = (sync != stable_o) && (dcnt == DW'(DEBOUNCE_CYCLES - 1));
  assign btn_req_o = flip && sync;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta     <= 1'b0;
      sync     <= 1'b0;
      stable_o <= 1'b0;
      dcnt     <= '0;
    end else begin
      meta     <= btn_i;
      sync     <= meta;
      stable_o <= flip ? sync : stable_o;
      dcnt     <= (flip || sync == stable_o) ? '0 : dcnt + 1'b1;
    end
  end
endmodule

// File: rtl/riscv_reset_seq.sv
// riscv_reset_seq: debounced button / watchdog reset sequencer releasing memory, then core
//  clk_i/reset_i : divided core clock, synchronous active-high reset
//  btn_i         : raw board reset button;  wdt_kick_i : watchdog kick from core
//  mem_rst_o/core_rst_o : active-high resets;  run_o : high in S_RUN
//  cause_o       : reset_cause_t of last sequence;  rst_cnt_o : saturating sequence count
//  Optional watchdog: define RISCV_RESET_SEQ_WDT_EN
module riscv_reset_seq
  import riscv_reset_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES     = 8,
  parameter int unsigned MEM_CYCLES      = 4,
  parameter int unsigned WDT_CYCLES      = 1024
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       btn_i,
  input  logic       wdt_kick_i,
  output logic       mem_rst_o,
  output logic       core_rst_o,
  output logic       run_o,
  output logic [1:0] cause_o,
  output logic [7:0] rst_cnt_o
);
  localparam int unsigned CW = $clog2(max2(HOLD_CYCLES, MEM_CYCLES) + 1);
  rst_state_t   state, state_d;
  reset_cause_t cause_q, cause_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [7:0]    rcnt_d;
  logic          btn_req;
  logic          btn_stable_unused;
  logic          expire;
  riscv_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .btn_i    (btn_i),
    .stable_o (btn_stable_unused),
    .btn_req_o(btn_req)
  );
`ifdef RISCV_RESET_SEQ_WDT_EN
  localparam int unsigned WW = $clog2(WDT_CYCLES);
  logic [WW-1:0] wcnt;
  // a kick on the expiry cycle wins
  assign expire = (state == S_RUN) && !wdt_kick_i && (wcnt == WW'(WDT_CYCLES - 1));
  always_ff @(posedge clk_i) begin
    wcnt <= (reset_i || wdt_kick_i || state != S_RUN || state_d != S_RUN) ? '0 : wcnt + 1'b1;
  end
`else
  logic kick_unused;
  assign kick_unused = wdt_kick_i;
  assign expire      = 1'b0;
`endif
  always_comb begin
    state_d = state;
    cnt_d   = cnt + 1'b1;
    cause_d = cause_q;
    rcnt_d  = rst_cnt_o;
    if (btn_req || expire) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      cause_d = btn_req ? CAUSE_BTN : CAUSE_WDT;
      rcnt_d  = rst_cnt_o + {7'd0, rst_cnt_o != 8'hFF};
    end else if (state == S_HOLD && cnt == CW'(HOLD_CYCLES - 1)) begin
      state_d = S_MEM;
      cnt_d   = '0;
    end else if (state == S_MEM && cnt == CW'(MEM_CYCLES - 1)) begin
      state_d = S_RUN;
      cnt_d   = '0;
    end else if (state == S_RUN) begin
      cnt_d   = '0;
    end
  end
  // outputs are decoded from the next state so they change on the same edge as the state
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= S_HOLD;
      cnt        <= '0;
      cause_q    <= CAUSE_POR;
      rst_cnt_o  <= 8'd0;
      mem_rst_o  <= 1'b1;
      core_rst_o <= 1'b1;
      run_o      <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      cause_q    <= cause_d;
      rst_cnt_o  <= rcnt_d;
      mem_rst_o  <= state_d == S_HOLD;
      core_rst_o <= state_d != S_RUN;
      run_o      <= state_d == S_RUN;
    end
  end
  assign cause_o = cause_q;
endmodule

// File: tb/tb_riscv_reset_seq.sv
// tb_riscv_reset_seq: directed self-checking bench for riscv_reset_seq (D=4, H=8, M=4, W=32)
module tb_riscv_reset_seq;
  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       btn_i = 1'b0;
  logic       wdt_kick_i = 1'b1;
  logic       mem_rst_o, core_rst_o, run_o;
  logic [1:0] cause_o;
  logic [7:0] rst_cnt_o;
  int         total = 0;
  int         bad = 0;
  riscv_reset_seq #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (8),
    .MEM_CYCLES     (4),
    .WDT_CYCLES     (32)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset_i),
    .btn_i     (btn_i),
    .wdt_kick_i(wdt_kick_i),
    .mem_rst_o (mem_rst_o),
    .core_rst_o(core_rst_o),
    .run_o     (run_o),
    .cause_o   (cause_o),
    .rst_cnt_o (rst_cnt_o)
  );
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic m, input logic c, input logic r,
                         input logic [1:0] cs, input logic [7:0] n);
    chk({tag, ".mem"}, {7'd0, mem_rst_o}, {7'd0, m});
    chk({tag, ".core"}, {7'd0, core_rst_o}, {7'd0, c});
    chk({tag, ".run"}, {7'd0, run_o}, {7'd0, r});
    chk({tag, ".cause"}, {6'd0, cause_o}, {6'd0, cs});
    chk({tag, ".cnt"}, rst_cnt_o, n);
  endtask
  initial begin
    step(1);
    chk_out("por", 1, 1, 0, 0, 0);
    reset_i = 1'b0;
    step(7);
    chk("hold7_mem", {7'd0, mem_rst_o}, 8'd1);
    step(1);
    chk_out("mem_on", 0, 1, 0, 0, 0);
    step(3);
    chk("mem3_core", {7'd0, core_rst_o}, 8'd1);
    step(1);
    chk_out("run_on", 0, 0, 1, 0, 0);
`ifdef RISCV_RESET_SEQ_WDT_EN
    wdt_kick_i = 1'b0;
    step(31);
    chk("wdt31_run", {7'd0, run_o}, 8'd1);
    step(1);
    chk_out("wdt_fire", 1, 1, 0, 2, 1);
    step(12);
    chk("wdt_rerun", {7'd0, run_o}, 8'd1);
    repeat (3) begin
      step(30);
      wdt_kick_i = 1'b1;
      step(1);
      wdt_kick_i = 1'b0;
    end
    chk_out("wdt_kicked", 0, 0, 1, 2, 1);
    step(26);
    btn_i = 1'b1;
    step(5);
    chk("wdt_btn_pre", {7'd0, run_o}, 8'd1);
    step(1);
    chk_out("wdt_btn_same", 1, 1, 0, 1, 2);
    btn_i = 1'b0;
    wdt_kick_i = 1'b1;
    reset_i = 1'b1;
    step(1);
    reset_i = 1'b0;
    step(12);
    chk_out("wdt_rearm", 0, 0, 1, 0, 0);
`endif
    btn_i = 1'b1;
    step(5);
    chk("btn5_core", {7'd0, core_rst_o}, 8'd0);
    step(1);
    chk_out("btn6", 1, 1, 0, 1, 1);
    step(8);
    chk_out("btn_mem", 0, 1, 0, 1, 1);
    step(4);
    chk_out("btn_run", 0, 0, 1, 1, 1);
    step(20);
    chk_out("btn_held", 0, 0, 1, 1, 1);
    btn_i = 1'b0;
    step(10);
    chk_out("btn_release", 0, 0, 1, 1, 1);
    btn_i = 1'b1;
    step(3);
    btn_i = 1'b0;
    step(12);
    chk_out("pulse3", 0, 0, 1, 1, 1);
    btn_i = 1'b1;
    step(2);
    btn_i = 1'b0;
    step(1);
    btn_i = 1'b1;
    step(2);
    btn_i = 1'b0;
    step(12);
    chk_out("glitch", 0, 0, 1, 1, 1);
    btn_i = 1'b1;
    step(6);
    chk_out("req2", 1, 1, 0, 1, 2);
    btn_i = 1'b0;
    step(4);
    btn_i = 1'b1;
    step(4);
    chk_out("mid_mem0", 0, 1, 0, 1, 2);
    step(1);
    chk_out("mid_mem1", 0, 1, 0, 1, 2);
    step(1);
    chk_out("mid_mem_req", 1, 1, 0, 1, 3);
    step(7);
    chk("restart_hold7", {7'd0, mem_rst_o}, 8'd1);
    step(1);
    chk("restart_mem", {7'd0, mem_rst_o}, 8'd0);
    step(3);
    chk("restart_core", {7'd0, core_rst_o}, 8'd1);
    step(1);
    chk_out("restart_run", 0, 0, 1, 1, 3);
    repeat (252) begin
      btn_i = 1'b0;
      step(8);
      btn_i = 1'b1;
      step(8);
    end
    chk("sat_reach", rst_cnt_o, 8'd255);
    repeat (10) begin
      btn_i = 1'b0;
      step(8);
      btn_i = 1'b1;
      step(8);
    end
    chk_out("sat_hold", 1, 1, 0, 1, 255);
    btn_i = 1'b0;
    step(20);
    chk_out("sat_run", 0, 0, 1, 1, 255);
    btn_i = 1'b1;
    step(3);
    reset_i = 1'b1;
    btn_i = 1'b0;
    step(1);
    chk_out("mid_reset", 1, 1, 0, 0, 0);
    reset_i = 1'b0;
    step(12);
    chk_out("post_reset_run", 0, 0, 1, 0, 0);
    step(10);
    chk_out("no_stale_req", 0, 0, 1, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
